// File: rtl/grid_cell_arbiter.sv
// grid_cell_arbiter
// Holds the colour of every cell of the 4x4 board. Game logic (A) and user
// input (B) share one write port under round-robin arbitration. A fill
// sweep can paint every cell with one colour, and the VGA renderer reads
// cells through a registered, read-before-write port.
module grid_cell_arbiter #(
    parameter int              CELLS     = 16,
    parameter int              AW        = 4,
    parameter int              DW        = 3,
    parameter logic [DW-1:0]   RST_COLOR = 3'b000
) (
    input  logic          clk,
    input  logic          rst,

    input  logic [AW-1:0] posicion,
    output logic [DW-1:0] dirColor,

    input  logic          a_req,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_data,
    output logic          a_ack,

    input  logic          b_req,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_data,
    output logic          b_ack,

    input  logic          fill_start,
    input  logic [DW-1:0] fill_color,
    output logic          busy,
    output logic          fill_done
);

    localparam logic [0:0]    ST_IDLE  = 1'b0;
    localparam logic [0:0]    ST_FILL  = 1'b1;
    localparam logic [AW-1:0] CNT_LAST = AW'(CELLS - 1);

    logic [0:0]    state;
    logic [AW-1:0] cnt;
    logic [DW-1:0] fill_col;
    // High when B received the most recent grant; A then wins the next tie.
    logic          last_b;

    logic          grant_a;
    logic          grant_b;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;

    logic [DW-1:0] cells [CELLS];

    // Arbitration and write-port selection. A fill_start cycle in IDLE
    // grants nobody, so pending requests simply wait out the sweep.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        if (state == ST_FILL) begin
            wr_en   = 1'b1;
            wr_addr = cnt;
            wr_data = fill_col;
        end else if (!fill_start) begin
            if (a_req && (!b_req || last_b)) begin
                grant_a = 1'b1;
            end else if (b_req) begin
                grant_b = 1'b1;
            end
            if (grant_a) begin
                wr_en   = 1'b1;
                wr_addr = a_addr;
                wr_data = a_data;
            end else if (grant_b) begin
                wr_en   = 1'b1;
                wr_addr = b_addr;
                wr_data = b_data;
            end
        end
    end

    assign a_ack = grant_a;
    assign b_ack = grant_b;
    assign busy  = (state == ST_FILL);

    // Control: IDLE/FILL sequencing, sweep counter, round-robin history and
    // the single-cycle fill_done pulse raised by the final sweep write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            fill_col  <= RST_COLOR;
            last_b    <= 1'b1;
            fill_done <= 1'b0;
        end else begin
            fill_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (fill_start) begin
                        state    <= ST_FILL;
                        cnt      <= '0;
                        fill_col <= fill_color;
                    end else if (grant_a) begin
                        last_b <= 1'b0;
                    end else if (grant_b) begin
                        last_b <= 1'b1;
                    end
                end
                ST_FILL: begin
                    // fill_start is deliberately not looked at here, so a
                    // running sweep cannot be restarted.
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        state     <= ST_IDLE;
                        cnt       <= '0;
                        fill_done <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Cell storage: one write per cycle from whichever source owns the port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CELLS; i++) begin
                cells[i] <= RST_COLOR;
            end
        end else if (wr_en) begin
            cells[wr_addr] <= wr_data;
        end
    end

    // Registered read port; sampling the array at the same edge as a write
    // returns the pre-write colour.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dirColor <= RST_COLOR;
        end else begin
            dirColor <= cells[posicion];
        end
    end

endmodule

// File: tb/tb_grid_cell_arbiter.sv
// Directed bench for grid_cell_arbiter: reset, single writes, contention,
// round-robin, read-before-write, fill sweeps with stalled requests,
// mid-fill reset and ignored restart.
module tb_grid_cell_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] posicion;
    logic [2:0] dir_color;
    logic       a_req, b_req;
    logic [3:0] a_addr, b_addr;
    logic [2:0] a_data, b_data;
    logic       a_ack, b_ack;
    logic       fill_start;
    logic [2:0] fill_color;
    logic       busy, fill_done;

    int n_checks = 0;
    int n_fail   = 0;

    grid_cell_arbiter #(
        .CELLS(16), .AW(4), .DW(3), .RST_COLOR(3'b000)
    ) dut (
        .clk(clk), .rst(rst),
        .posicion(posicion), .dirColor(dir_color),
        .a_req(a_req), .a_addr(a_addr), .a_data(a_data), .a_ack(a_ack),
        .b_req(b_req), .b_addr(b_addr), .b_data(b_data), .b_ack(b_ack),
        .fill_start(fill_start), .fill_color(fill_color),
        .busy(busy), .fill_done(fill_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       a_req;
        logic [3:0] a_addr;
        logic [2:0] a_data;
        logic       b_req;
        logic [3:0] b_addr;
        logic [2:0] b_data;
        logic [3:0] pos;
        logic       exp_a;
        logic       exp_b;
        logic [2:0] exp_dir;
    } vec_t;

    vec_t vecs [17];

    function automatic vec_t mk(input logic ar, input logic [3:0] aa, input logic [2:0] ad,
                                input logic br, input logic [3:0] ba, input logic [2:0] bd,
                                input logic [3:0] p, input logic ea, input logic eb,
                                input logic [2:0] ed);
        vec_t v;
        v.a_req = ar; v.a_addr = aa; v.a_data = ad;
        v.b_req = br; v.b_addr = ba; v.b_data = bd;
        v.pos = p; v.exp_a = ea; v.exp_b = eb; v.exp_dir = ed;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Must be entered 1 time unit after a rising edge.
    task automatic sweep(input string tag, input logic [2:0] c9, input logic [2:0] other);
        for (int i = 0; i < 16; i++) begin
            posicion = 4'(i);
            @(posedge clk); #1;
            check($sformatf("%s_cell%0d", tag, i), 32'(dir_color),
                  32'((i == 9) ? c9 : other));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_cycles;
        int done_cnt;

        // Rows are applied 1 unit after an edge and checked at the falling
        // edge. dirColor in a row shows the cell addressed by the previous
        // row's posicion, as stored before the previous row's write.
        vecs[0]  = mk(1, 5, 3'b100, 0, 0, 3'b000, 5, 1, 0, 3'b000);
        vecs[1]  = mk(0, 0, 3'b000, 1, 9, 3'b011, 5, 0, 1, 3'b000);
        vecs[2]  = mk(0, 0, 3'b000, 0, 0, 3'b000, 5, 0, 0, 3'b100);
        vecs[3]  = mk(1, 2, 3'b010, 1, 2, 3'b001, 2, 1, 0, 3'b100);
        vecs[4]  = mk(0, 2, 3'b010, 1, 2, 3'b001, 2, 0, 1, 3'b000);
        vecs[5]  = mk(0, 0, 3'b000, 0, 0, 3'b000, 2, 0, 0, 3'b010);
        vecs[6]  = mk(0, 0, 3'b000, 0, 0, 3'b000, 2, 0, 0, 3'b001);
        vecs[7]  = mk(1, 0, 3'b001, 1, 1, 3'b010, 9, 1, 0, 3'b001);
        vecs[8]  = mk(1, 0, 3'b001, 1, 1, 3'b010, 9, 0, 1, 3'b011);
        vecs[9]  = mk(1, 0, 3'b001, 1, 1, 3'b010, 9, 1, 0, 3'b011);
        vecs[10] = mk(1, 0, 3'b001, 1, 1, 3'b010, 9, 0, 1, 3'b011);
        vecs[11] = mk(1, 7, 3'b011, 0, 0, 3'b000, 7, 1, 0, 3'b011);
        vecs[12] = mk(0, 0, 3'b000, 0, 0, 3'b000, 7, 0, 0, 3'b000);
        vecs[13] = mk(0, 0, 3'b000, 0, 0, 3'b000, 0, 0, 0, 3'b011);
        vecs[14] = mk(0, 0, 3'b000, 0, 0, 3'b000, 1, 0, 0, 3'b001);
        vecs[15] = mk(0, 0, 3'b000, 0, 0, 3'b000, 1, 0, 0, 3'b010);
        vecs[16] = mk(0, 0, 3'b000, 0, 0, 3'b000, 0, 0, 0, 3'b010);

        rst = 1'b1; posicion = '0;
        a_req = 0; a_addr = '0; a_data = '0;
        b_req = 0; b_addr = '0; b_data = '0;
        fill_start = 0; fill_color = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Put non-reset values on the outputs, then reset mid-cycle.
        a_req = 1; a_addr = 4'd0; a_data = 3'b101;
        @(posedge clk); #1 a_req = 0;
        @(posedge clk); #1 fill_start = 1; fill_color = 3'b110;
        @(posedge clk); #1 fill_start = 0;
        #1;
        check("pre_rst_busy", 32'(busy), 32'd1);
        check("pre_rst_dir", 32'(dir_color), 32'(3'b101));
        #2 rst = 1'b1;
        #1;
        check("async_rst_dir", 32'(dir_color), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_done", 32'(fill_done), 32'd0);
        check("async_rst_a_ack", 32'(a_ack), 32'd0);
        check("async_rst_b_ack", 32'(b_ack), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        sweep("rst", 3'b000, 3'b000);

        // Single writes, contention, round-robin, read-before-write.
        for (int i = 0; i < 17; i++) begin
            a_req = vecs[i].a_req; a_addr = vecs[i].a_addr; a_data = vecs[i].a_data;
            b_req = vecs[i].b_req; b_addr = vecs[i].b_addr; b_data = vecs[i].b_data;
            posicion = vecs[i].pos;
            @(negedge clk);
            check($sformatf("vec%0d_a_ack", i), 32'(a_ack), 32'(vecs[i].exp_a));
            check($sformatf("vec%0d_b_ack", i), 32'(b_ack), 32'(vecs[i].exp_b));
            check($sformatf("vec%0d_dir", i), 32'(dir_color), 32'(vecs[i].exp_dir));
            @(posedge clk); #1;
        end

        // Fill with B stalled behind it.
        fill_start = 1; fill_color = 3'b111;
        a_req = 0;
        b_req = 1; b_addr = 4'd9; b_data = 3'b001;
        @(negedge clk);
        check("fill_start_b_ack", 32'(b_ack), 32'd0);
        check("fill_start_busy", 32'(busy), 32'd0);
        @(posedge clk); #1 fill_start = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            check($sformatf("fill_busy_c%0d", c), 32'(busy), 32'd1);
            check($sformatf("fill_b_ack_c%0d", c), 32'(b_ack), 32'd0);
            check($sformatf("fill_done_c%0d", c), 32'(fill_done), 32'd0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("fill_end_busy", 32'(busy), 32'd0);
        check("fill_end_done", 32'(fill_done), 32'd1);
        check("fill_end_b_ack", 32'(b_ack), 32'd1);
        @(posedge clk); #1 b_req = 0;
        @(negedge clk);
        check("fill_done_pulse_end", 32'(fill_done), 32'd0);
        @(posedge clk); #1;
        sweep("fill", 3'b001, 3'b111);

        // Reset at fill cycle 8 aborts the sweep.
        fill_start = 1; fill_color = 3'b101;
        @(posedge clk); #1 fill_start = 0;
        repeat (8) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(fill_done), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        busy_cycles = 0; done_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (busy) busy_cycles++;
            if (fill_done) done_cnt++;
        end
        check("abort_busy_after", 32'(busy_cycles), 32'd0);
        check("abort_no_done", 32'(done_cnt), 32'd0);
        @(posedge clk); #1;
        sweep("abort", 3'b000, 3'b000);

        // Second fill_start during a running sweep is ignored.
        fill_start = 1; fill_color = 3'b011;
        @(posedge clk); #1 fill_start = 0;
        busy_cycles = 0; done_cnt = 0;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            if (busy) busy_cycles++;
            if (fill_done) done_cnt++;
            if (c == 4) begin
                fill_start = 1; fill_color = 3'b100;
            end else begin
                fill_start = 0;
            end
            @(posedge clk);
        end
        #1;
        check("restart_busy_cycles", 32'(busy_cycles), 32'd16);
        check("restart_done_count", 32'(done_cnt), 32'd1);
        sweep("restart", 3'b011, 3'b011);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
